// File: rtl/key_move_pkg.sv
// Shared direction codes and FSM state encoding for the key-to-move path.
package key_move_pkg;
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;
endpackage

// File: rtl/key_edge_prio.sv
// Rising-edge detector over the four keys with a fixed-priority pick (up wins).
// Edge is combinational on the current level; key_prev is one flop stage.
module key_edge_prio
  import key_move_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_key_db,
  output logic       o_rise_any,
  output logic [1:0] o_idx
);
  logic [3:0] r_key_prev;
  logic [3:0] w_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_key_prev <= 4'b0000;
    else        r_key_prev <= i_key_db;
  end

  assign w_rise     = i_key_db & ~r_key_prev;
  assign o_rise_any = |w_rise;

  always_comb begin
    o_idx = DIR_UP;
    if      (w_rise[0]) o_idx = DIR_UP;
    else if (w_rise[1]) o_idx = DIR_DOWN;
    else if (w_rise[2]) o_idx = DIR_LEFT;
    else if (w_rise[3]) o_idx = DIR_RIGHT;
  end
endmodule

// File: rtl/key_move_ctrl.sv
// Turns debounced direction keys into move commands: one per press plus auto-repeat while held.
// Command lands in a single-entry valid/ready register one cycle after the event edge.
module key_move_ctrl
  import key_move_pkg::*;
#(
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int CNT_W         = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_db,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic       move_drop,
  output logic       key_held
);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_act_idx, w_act_idx_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_rise_any;
  logic [1:0]       w_pick;
  logic             w_evt;
  logic [1:0]       w_evt_dir;

  key_edge_prio u_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_key_db   (key_db),
    .o_rise_any (w_rise_any),
    .o_idx      (w_pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_act_idx <= 2'd0;
      r_cnt     <= '0;
      key_held  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_act_idx <= w_act_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      key_held  <= (w_state_nxt != IDLE);
    end
  end

  // A new press always preempts; release beats a terminal count on the same edge.
  always_comb begin
    w_state_nxt   = r_state;
    w_act_idx_nxt = r_act_idx;
    w_cnt_nxt     = r_cnt;
    w_evt         = 1'b0;
    w_evt_dir     = w_pick;
    case (r_state)
      IDLE: begin
        if (w_rise_any) begin
          w_evt         = 1'b1;
          w_act_idx_nxt = w_pick;
          w_cnt_nxt     = '0;
          w_state_nxt   = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (w_rise_any) begin
          w_evt         = 1'b1;
          w_act_idx_nxt = w_pick;
          w_cnt_nxt     = '0;
          w_state_nxt   = DELAY;
        end else if (!key_db[r_act_idx]) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if ((r_state == DELAY && r_cnt == DELAY_LAST) ||
                     (r_state == REPEAT && r_cnt == PERIOD_LAST)) begin
          w_evt       = 1'b1;
          w_evt_dir   = r_act_idx;
          w_cnt_nxt   = '0;
          w_state_nxt = REPEAT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      move_valid <= 1'b0;
      move_dir   <= 2'd0;
      move_drop  <= 1'b0;
    end else begin
      move_drop <= 1'b0;
      if (w_evt) begin
        if (!move_valid || move_ready) begin
          move_valid <= 1'b1;
          move_dir   <= w_evt_dir;
        end else begin
          move_drop <= 1'b1;
        end
      end else if (move_valid && move_ready) begin
        move_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_key_move_ctrl.sv
// Scoreboard bench for key_move_ctrl with REPEAT_DELAY=8, REPEAT_PERIOD=4.
module tb_key_move_ctrl;
  import key_move_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_db;
  logic       move_ready;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       move_drop;
  logic       key_held;

  key_move_ctrl #(
    .REPEAT_DELAY  (8),
    .REPEAT_PERIOD (4),
    .CNT_W         (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_db     (key_db),
    .move_ready (move_ready),
    .move_valid (move_valid),
    .move_dir   (move_dir),
    .move_drop  (move_drop),
    .key_held   (key_held)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int dir;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   n_chk    = 0;
  int   n_pass   = 0;
  int   drop_cnt = 0;

  task automatic check(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
  endtask

  task automatic push(input int c, input int d);
    exp_t e;
    e.cyc = c;
    e.dir = d;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // A transfer happens at the next rising edge whenever valid && ready at the falling edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (move_drop) drop_cnt++;
        if (move_valid && move_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_cmd", int'(move_dir), -1);
          end else begin
            e = exp_q.pop_front();
            check("cmd_dir", int'(move_dir), e.dir);
            check("cmd_cycle", cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin : stim
    int c;
    int d0;
    rst_n      = 1'b0;
    key_db     = 4'b1111;
    move_ready = 1'b1;

    for (int i = 0; i < 3; i++) begin
      step(1);
      check("rst_valid", int'(move_valid), 0);
      check("rst_drop", int'(move_drop), 0);
      check("rst_held", int'(key_held), 0);
    end
    key_db = 4'b0000;
    step(1);
    rst_n = 1'b1;
    step(3);

    // Short press of up.
    c = cyc;
    key_db = 4'b0001;
    push(c + 1, DIR_UP);
    step(3);
    check("short_held_hi", int'(key_held), 1);
    key_db = 4'b0000;
    step(2);
    check("short_held_lo", int'(key_held), 0);
    step(4);

    // Right held for 20 samples: events at E0, +8, +12, +16; release wins at +20.
    c = cyc;
    key_db = 4'b1000;
    push(c + 1, DIR_RIGHT);
    push(c + 9, DIR_RIGHT);
    push(c + 13, DIR_RIGHT);
    push(c + 17, DIR_RIGHT);
    step(20);
    key_db = 4'b0000;
    step(6);
    check("hold_q_empty", exp_q.size(), 0);

    // Backpressure: up pending, left press dropped, then accepted.
    d0 = drop_cnt;
    c = cyc;
    move_ready = 1'b0;
    key_db = 4'b0001;
    push(c + 10, DIR_UP);
    step(2);
    key_db = 4'b0000;
    step(3);
    key_db = 4'b0100;
    step(2);
    key_db = 4'b0000;
    step(1);
    check("bp_valid", int'(move_valid), 1);
    check("bp_dir", int'(move_dir), DIR_UP);
    step(2);
    move_ready = 1'b1;
    step(1);
    check("bp_valid_clr", int'(move_valid), 0);
    check("bp_drops", drop_cnt - d0, 1);
    step(4);

    // Arbitration: up+left together picks up; later down preempts and repeats alone.
    c = cyc;
    key_db = 4'b0101;
    push(c + 1, DIR_UP);
    step(3);
    key_db = 4'b0111;
    push(c + 4, DIR_DOWN);
    push(c + 12, DIR_DOWN);
    step(10);
    key_db = 4'b0000;
    step(6);
    check("arb_q_empty", exp_q.size(), 0);

    // Reset while repeating right with a command pending.
    d0 = drop_cnt;
    c = cyc;
    move_ready = 1'b0;
    key_db = 4'b1000;
    step(11);
    check("pre_rst_valid", int'(move_valid), 1);
    check("pre_rst_drops", drop_cnt - d0, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", int'(move_valid), 0);
    check("async_rst_held", int'(key_held), 0);
    step(2);
    c = cyc;
    rst_n = 1'b1;
    move_ready = 1'b1;
    push(c + 1, DIR_RIGHT);
    push(c + 9, DIR_RIGHT);
    step(10);
    key_db = 4'b0000;
    step(8);
    check("final_q_empty", exp_q.size(), 0);
    check("final_held", int'(key_held), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
